zsdram_rw_arbiter: RTL and testbench

Parametrised successor to the fixed two-read/two-write SDRAM port multiplexer. It arbitrates NUM_RD read ports and NUM_WR write ports onto the single SDRAM controller read/write glue interface. Each transaction is one burst of BURST words. Arbitration is fixed-priority or round-robin, and a per-transaction watchdog aborts transactions the controller never completes. The block sits between the SDRAM controller and its clients (TFT adapter, draw/shift engines).

---
 rtl/zsdram_mux_pkg.sv | 19 +
 rtl/zsdram_rr_arbiter.sv | 35 +++
 rtl/zsdram_rw_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_zsdram_rw_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zsdram_mux_pkg.sv
// Shared types and helpers for the SDRAM read/write port arbiter.
package zsdram_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Width needed to index n ports; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/zsdram_rr_arbiter.sv
// Combinational winner select: fixed priority or round-robin after a pointer.
module zsdram_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_mode,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Pick the requester closest after the pointer (rr) or the lowest index (fixed).
  always_comb begin : p_select
    int d;
    int best_d;
    d      = 0;
    best_d = N;
    o_idx  = '0;
    o_valid = |i_req;
    for (int i = 0; i < N; i++) begin
      if (i_mode) begin
        d = i - int'(i_ptr) - 1;
        if (d < 0) d = d + N;
      end else begin
        d = i;
      end
      if (i_req[i] && (d < best_d)) begin
        best_d = d;
        o_idx  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/zsdram_rw_arbiter.sv
// Arbitrates NUM_RD read and NUM_WR write clients onto one SDRAM controller port.
//
// state | meaning
// IDLE  | wait for any client request, latch winner and raise controller request
// ISSUE | request held until controller done or watchdog expiry
// DONE  | one-cycle done pulse to the granted client
// GAP   | turnaround cycle, watchdog cleared
module zsdram_rw_arbiter
  import zsdram_mux_pkg::*;
#(
  parameter int NUM_RD      = 2,
  parameter int NUM_WR      = 2,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int BURST       = 4,
  parameter int ARB_MODE    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  output logic                             oRd_Req,
  output logic [ADDR_W-1:0]                oRd_Addr,
  input  logic                             iRd_Done,
  input  logic [BURST*DATA_W-1:0]          iRd_Data,
  output logic                             oWr_Req,
  output logic [ADDR_W-1:0]                oWr_Addr,
  output logic [BURST*DATA_W-1:0]          oWr_Data,
  input  logic                             iWr_Done,
  input  logic [NUM_RD-1:0]                iRd_Req,
  input  logic [NUM_RD*ADDR_W-1:0]         iRd_Addr,
  output logic [NUM_RD-1:0]                oRd_Done,
  output logic [NUM_RD*BURST*DATA_W-1:0]   oRd_Data,
  input  logic [NUM_WR-1:0]                iWr_Req,
  input  logic [NUM_WR*ADDR_W-1:0]         iWr_Addr,
  input  logic [NUM_WR*BURST*DATA_W-1:0]   iWr_Data,
  output logic [NUM_WR-1:0]                oWr_Done,
  output logic                             oBusy,
  output logic                             oTimeout,
  output logic [idx_width(NUM_RD+NUM_WR)-1:0] oErr_Port
);

  localparam int N     = NUM_RD + NUM_WR;
  localparam int IDX_W = idx_width(N);
  localparam int BW    = BURST * DATA_W;
  localparam int WD_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam bit WD_EN = (TIMEOUT_CYC > 0);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_grant;
  logic [IDX_W-1:0]         r_ptr;
  logic [WD_W-1:0]          r_wdog;
  logic                     r_rd_req;
  logic                     r_wr_req;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic [BW-1:0]            r_wr_data;
  logic [NUM_RD-1:0]        r_rd_done;
  logic [NUM_WR-1:0]        r_wr_done;
  logic [NUM_RD*BW-1:0]     r_rd_data;
  logic                     r_busy;
  logic                     r_timeout;
  logic [IDX_W-1:0]         r_err_port;

  logic [N-1:0]             w_req;
  logic [IDX_W-1:0]         w_win_idx;
  logic                     w_win_valid;
  logic                     w_win_is_rd;
  logic                     w_grant_is_rd;
  logic                     w_ctl_done;
  logic [ADDR_W-1:0]        w_sel_rd_addr;
  logic [ADDR_W-1:0]        w_sel_wr_addr;
  logic [BW-1:0]            w_sel_wr_data;

  assign w_req         = {iWr_Req, iRd_Req};
  assign w_win_is_rd   = (w_win_idx < IDX_W'(NUM_RD));
  assign w_grant_is_rd = (r_grant < IDX_W'(NUM_RD));
  assign w_ctl_done    = w_grant_is_rd ? iRd_Done : iWr_Done;

  zsdram_rr_arbiter #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .i_mode  (ARB_MODE == ARB_RR),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  // Route the winning client's address and write burst toward the controller regs.
  always_comb begin
    w_sel_rd_addr = '0;
    w_sel_wr_addr = '0;
    w_sel_wr_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (w_win_idx == IDX_W'(i)) w_sel_rd_addr = iRd_Addr[i*ADDR_W +: ADDR_W];
    end
    for (int i = 0; i < NUM_WR; i++) begin
      if (w_win_idx == IDX_W'(NUM_RD + i)) begin
        w_sel_wr_addr = iWr_Addr[i*ADDR_W +: ADDR_W];
        w_sel_wr_data = iWr_Data[i*BW +: BW];
      end
    end
  end

  // Transaction FSM with all outputs registered; en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_ptr      <= IDX_W'(N - 1);
      r_wdog     <= '0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_done  <= '0;
      r_wr_done  <= '0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err_port <= '0;
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_grant <= w_win_idx;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
            if (w_win_is_rd) begin
              r_rd_req  <= 1'b1;
              r_rd_addr <= w_sel_rd_addr;
            end else begin
              r_wr_req  <= 1'b1;
              r_wr_addr <= w_sel_wr_addr;
              r_wr_data <= w_sel_wr_data;
            end
          end
        end
        ISSUE: begin
          if (w_ctl_done) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_ptr    <= r_grant;
            for (int i = 0; i < NUM_RD; i++) begin
              r_rd_done[i] <= (r_grant == IDX_W'(i));
              if (r_grant == IDX_W'(i)) r_rd_data[i*BW +: BW] <= iRd_Data;
            end
            for (int i = 0; i < NUM_WR; i++) begin
              r_wr_done[i] <= (r_grant == IDX_W'(NUM_RD + i));
            end
            r_state <= DONE;
          end else if (WD_EN && (r_wdog == WD_LAST)) begin
            // Controller never answered: abandon without a done pulse.
            r_rd_req   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_ptr      <= r_grant;
            r_timeout  <= 1'b1;
            r_err_port <= r_grant;
            r_state    <= GAP;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        DONE: begin
          r_rd_done <= '0;
          r_wr_done <= '0;
          r_state   <= GAP;
        end
        GAP: begin
          r_timeout <= 1'b0;
          r_wdog    <= '0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign oRd_Req   = r_rd_req;
  assign oRd_Addr  = r_rd_addr;
  assign oWr_Req   = r_wr_req;
  assign oWr_Addr  = r_wr_addr;
  assign oWr_Data  = r_wr_data;
  assign oRd_Done  = r_rd_done;
  assign oRd_Data  = r_rd_data;
  assign oWr_Done  = r_wr_done;
  assign oBusy     = r_busy;
  assign oTimeout  = r_timeout;
  assign oErr_Port = r_err_port;

endmodule

// File: tb/tb_zsdram_rw_arbiter.sv
// Scoreboard bench: round-robin instance with watchdog, plus a fixed-priority instance.
module tb_zsdram_rw_arbiter;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 24;
  localparam int BW = 64;
  localparam logic [AW-1:0] A0 = 24'h000100;
  localparam logic [AW-1:0] A1 = 24'h000230;
  localparam logic [AW-1:0] W0 = 24'h00A000;
  localparam logic [AW-1:0] W1 = 24'h00B004;
  localparam logic [BW-1:0] D0 = 64'h0D0C_0B0A_0908_0706;
  localparam logic [BW-1:0] D1 = 64'hF1E2_D3C4_B5A6_9788;
  localparam logic [AW-1:0] FA0 = 24'h00C000;
  localparam logic [BW-1:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    int           port;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
    bit           timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en;
  always #5 clk = ~clk;

  // main (round-robin) instance signals
  logic               m_oRd_Req, m_oWr_Req, m_iRd_Done, m_iWr_Done;
  logic [AW-1:0]      m_oRd_Addr, m_oWr_Addr;
  logic [BW-1:0]      m_iRd_Data, m_oWr_Data;
  logic [NR-1:0]      m_rd_req, m_rd_done;
  logic [NR*AW-1:0]   m_rd_addr;
  logic [NR*BW-1:0]   m_rd_data;
  logic [NW-1:0]      m_wr_req, m_wr_done;
  logic [NW*AW-1:0]   m_wr_addr;
  logic [NW*BW-1:0]   m_wr_data;
  logic               m_busy, m_timeout;
  logic [1:0]         m_err_port;

  // fixed-priority instance signals
  logic               f_oRd_Req, f_oWr_Req, f_iRd_Done, f_iWr_Done;
  logic [AW-1:0]      f_oRd_Addr, f_oWr_Addr;
  logic [BW-1:0]      f_iRd_Data, f_oWr_Data;
  logic [NR-1:0]      f_rd_req, f_rd_done;
  logic [NR*AW-1:0]   f_rd_addr;
  logic [NR*BW-1:0]   f_rd_data;
  logic [NW-1:0]      f_wr_req, f_wr_done;
  logic [NW*AW-1:0]   f_wr_addr;
  logic [NW*BW-1:0]   f_wr_data;
  logic               f_busy, f_timeout;
  logic [1:0]         f_err_port;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  int   rd_lat, wr_lat;
  bit   hang_wr;
  bit   chk_width;
  int   f_cnt[4];
  int   f_wr_rise;

  zsdram_rw_arbiter #(
    .NUM_RD(NR), .NUM_WR(NW), .ADDR_W(AW), .DATA_W(16), .BURST(4),
    .ARB_MODE(1), .TIMEOUT_CYC(8)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .oRd_Req(m_oRd_Req), .oRd_Addr(m_oRd_Addr), .iRd_Done(m_iRd_Done), .iRd_Data(m_iRd_Data),
    .oWr_Req(m_oWr_Req), .oWr_Addr(m_oWr_Addr), .oWr_Data(m_oWr_Data), .iWr_Done(m_iWr_Done),
    .iRd_Req(m_rd_req), .iRd_Addr(m_rd_addr), .oRd_Done(m_rd_done), .oRd_Data(m_rd_data),
    .iWr_Req(m_wr_req), .iWr_Addr(m_wr_addr), .iWr_Data(m_wr_data), .oWr_Done(m_wr_done),
    .oBusy(m_busy), .oTimeout(m_timeout), .oErr_Port(m_err_port)
  );

  zsdram_rw_arbiter #(
    .NUM_RD(NR), .NUM_WR(NW), .ADDR_W(AW), .DATA_W(16), .BURST(4),
    .ARB_MODE(0), .TIMEOUT_CYC(8)
  ) u_dut_fp (
    .clk(clk), .rst(rst), .en(en),
    .oRd_Req(f_oRd_Req), .oRd_Addr(f_oRd_Addr), .iRd_Done(f_iRd_Done), .iRd_Data(f_iRd_Data),
    .oWr_Req(f_oWr_Req), .oWr_Addr(f_oWr_Addr), .oWr_Data(f_oWr_Data), .iWr_Done(f_iWr_Done),
    .iRd_Req(f_rd_req), .iRd_Addr(f_rd_addr), .oRd_Done(f_rd_done), .oRd_Data(f_rd_data),
    .iWr_Req(f_wr_req), .iWr_Addr(f_wr_addr), .iWr_Data(f_wr_data), .oWr_Done(f_wr_done),
    .oBusy(f_busy), .oTimeout(f_timeout), .oErr_Port(f_err_port)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Controller read data model: fixed pattern for the reference address.
  function automatic logic [BW-1:0] ctrl_rd_data(input logic [AW-1:0] a);
    if (a == 24'h000100) return 64'h4444_3333_2222_1111;
    return {a[15:0], ~a[15:0], a[15:0] ^ 16'h5A5A, a[15:0] + 16'h1};
  endfunction

  // Controller model for the main instance (drives away from the active edge).
  int m_rd_cnt, m_wr_cnt;
  always @(negedge clk) begin
    if (rst) begin
      m_rd_cnt = 0; m_wr_cnt = 0; m_iRd_Done = 1'b0; m_iWr_Done = 1'b0; m_iRd_Data = JUNK;
    end else if (en) begin
      if (m_oRd_Req && !m_iRd_Done) begin
        m_rd_cnt++;
        if (m_rd_cnt >= rd_lat) begin m_iRd_Done = 1'b1; m_iRd_Data = ctrl_rd_data(m_oRd_Addr); end
      end else begin
        m_rd_cnt = 0; m_iRd_Done = 1'b0; m_iRd_Data = JUNK;
      end
      if (m_oWr_Req && !m_iWr_Done && !hang_wr) begin
        m_wr_cnt++;
        if (m_wr_cnt >= wr_lat) m_iWr_Done = 1'b1;
      end else begin
        m_wr_cnt = 0; m_iWr_Done = 1'b0;
      end
    end
  end

  // Controller model for the fixed-priority instance, latency 2.
  int f_rd_cnt, f_wr_cnt;
  always @(negedge clk) begin
    if (rst) begin
      f_rd_cnt = 0; f_wr_cnt = 0; f_iRd_Done = 1'b0; f_iWr_Done = 1'b0; f_iRd_Data = JUNK;
    end else if (en) begin
      if (f_oRd_Req && !f_iRd_Done) begin
        f_rd_cnt++;
        if (f_rd_cnt >= 2) begin f_iRd_Done = 1'b1; f_iRd_Data = ctrl_rd_data(f_oRd_Addr); end
      end else begin
        f_rd_cnt = 0; f_iRd_Done = 1'b0; f_iRd_Data = JUNK;
      end
      if (f_oWr_Req && !f_iWr_Done) begin
        f_wr_cnt++;
        if (f_wr_cnt >= 2) f_iWr_Done = 1'b1;
      end else begin
        f_wr_cnt = 0; f_iWr_Done = 1'b0;
      end
    end
  end

  // Main scoreboard monitor: address on request rise, port/data on done, abort on timeout.
  logic p_rd, p_wr, p_done, p_to;
  int   done_len;
  always @(negedge clk) begin : mon_main
    exp_t e;
    int   obs;
    logic any_done;
    if (rst) begin
      p_rd = 0; p_wr = 0; p_done = 0; p_to = 0; done_len = 0;
    end else begin
      any_done = (|m_rd_done) || (|m_wr_done);
      if (m_oRd_Req && !p_rd) begin
        check_val("rd_req_expected", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) check_val("rd_addr", m_oRd_Addr, sb[0].addr);
      end
      if (m_oWr_Req && !p_wr) begin
        check_val("wr_req_expected", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          check_val("wr_addr", m_oWr_Addr, sb[0].addr);
          check_val("wr_data", m_oWr_Data, sb[0].data);
        end
      end
      if (any_done && !p_done) begin
        check_val("done_expected", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          obs = -1;
          for (int i = 0; i < NR; i++) if (m_rd_done[i]) obs = i;
          for (int i = 0; i < NW; i++) if (m_wr_done[i]) obs = NR + i;
          check_val("done_port", 64'(obs), 64'(e.port));
          check_val("done_onehot", 64'($countones({m_rd_done, m_wr_done})), 1);
          check_val("done_not_abort", 64'(e.timeout), 0);
          if (obs >= 0 && obs < NR) check_val("rd_data", m_rd_data[obs*BW +: BW], e.data);
        end
      end
      if (any_done) done_len++;
      else begin
        if (p_done && chk_width) check_val("done_width", 64'(done_len), 1);
        done_len = 0;
      end
      if (m_timeout && !p_to) begin
        check_val("timeout_expected", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_val("timeout_is_abort", 64'(e.timeout), 1);
          check_val("err_port", 64'(m_err_port), 64'(e.port));
        end
      end
      p_rd = m_oRd_Req; p_wr = m_oWr_Req; p_done = any_done; p_to = m_timeout;
    end
  end

  // Fixed-priority monitor: count done pulses per port and write grants.
  logic fp_rd, fp_wr;
  logic [3:0] fp_done;
  always @(negedge clk) begin
    if (rst) begin
      fp_rd = 0; fp_wr = 0; fp_done = '0;
    end else begin
      if (f_oRd_Req && !fp_rd) check_val("fp_rd_addr", f_oRd_Addr, FA0);
      if (f_oWr_Req && !fp_wr) f_wr_rise++;
      for (int i = 0; i < 4; i++) if ({f_wr_done, f_rd_done}[i] && !fp_done[i]) f_cnt[i]++;
      fp_rd = f_oRd_Req; fp_wr = f_oWr_Req; fp_done = {f_wr_done, f_rd_done};
    end
  end

  task automatic push(input int port, input logic [AW-1:0] a, input logic [BW-1:0] d, input bit to);
    exp_t e;
    e.port = port; e.addr = a; e.data = d; e.timeout = to;
    sb.push_back(e);
  endtask

  task automatic wait_any_done(output bit ok);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ((|m_rd_done) || (|m_wr_done)) begin ok = 1; break; end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    bit ok;
    int c;
    rst = 1; en = 1; hang_wr = 0; rd_lat = 3; wr_lat = 2; chk_width = 1; f_wr_rise = 0;
    for (int i = 0; i < 4; i++) f_cnt[i] = 0;
    m_rd_req = '0; m_wr_req = '0;
    m_rd_addr = {A1, A0}; m_wr_addr = {W1, W0}; m_wr_data = {D1, D0};
    f_rd_req = '0; f_wr_req = '0;
    f_rd_addr = {24'h00C100, FA0}; f_wr_addr = {24'h00C300, 24'h00C200}; f_wr_data = {D0, D1};
    repeat (3) @(negedge clk);
    check_val("rst_rd_req", m_oRd_Req, 0);
    check_val("rst_wr_req", m_oWr_Req, 0);
    check_val("rst_busy", m_busy, 0);
    check_val("rst_timeout", m_timeout, 0);
    check_val("rst_err_port", m_err_port, 0);
    check_val("rst_rd_data_zero", 64'(m_rd_data == '0), 1);
    check_val("rst_dones", {m_rd_done, m_wr_done}, 0);
    rst = 0;

    // 1: single read on port 0
    @(negedge clk);
    push(0, A0, ctrl_rd_data(A0), 0);
    m_rd_req[0] = 1;
    @(negedge clk);
    check_val("t1_req_latency", m_oRd_Req, 1);
    check_val("t1_busy", m_busy, 1);
    wait_any_done(ok);
    check_val("t1_done_seen", ok, 1);
    m_rd_req[0] = 0;
    repeat (3) @(negedge clk);
    check_val("t1_idle", m_busy, 0);

    // 2: all four requesting, round-robin from reset
    rst = 1; sb.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    push(0, A0, ctrl_rd_data(A0), 0);
    push(1, A1, ctrl_rd_data(A1), 0);
    push(2, W0, D0, 0);
    push(3, W1, D1, 0);
    push(0, A0, ctrl_rd_data(A0), 0);
    m_rd_req = 2'b11; m_wr_req = 2'b11;
    for (int i = 0; i < 5; i++) begin
      wait_any_done(ok);
      check_val("t2_done_seen", ok, 1);
      if (i == 4) begin m_rd_req = '0; m_wr_req = '0; end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_val("t2_sb_empty", 64'(sb.size()), 0);

    // 3: fixed priority instance, same stimulus pattern
    f_rd_req = 2'b11; f_wr_req = 2'b11;
    for (int i = 0; i < 5; i++) begin
      ok = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if ((|f_rd_done) || (|f_wr_done)) begin ok = 1; break; end
      end
      check_val("t3_done_seen", ok, 1);
      if (i == 4) begin f_rd_req = '0; f_wr_req = '0; end
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check_val("t3_port0_dones", 64'(f_cnt[0]), 5);
    check_val("t3_port1_dones", 64'(f_cnt[1]), 0);
    check_val("t3_port2_dones", 64'(f_cnt[2]), 0);
    check_val("t3_port3_dones", 64'(f_cnt[3]), 0);
    check_val("t3_wr_grants", 64'(f_wr_rise), 0);

    // 4: write port 1 never completes -> watchdog abort after 8 ISSUE cycles
    hang_wr = 1;
    push(3, W1, D1, 1);
    m_wr_req[1] = 1;
    for (c = 0; c < 50 && !m_oWr_Req; c++) @(negedge clk);
    check_val("t4_req_seen", m_oWr_Req, 1);
    for (c = 0; c < 50 && m_oWr_Req; c++) @(negedge clk);
    check_val("t4_issue_cycles", 64'(c), 8);
    check_val("t4_timeout_pulse", m_timeout, 1);
    m_wr_req[1] = 0;
    hang_wr = 0;
    @(negedge clk);
    check_val("t4_timeout_single", m_timeout, 0);
    push(2, W0, D0, 0);
    m_wr_req[0] = 1;
    wait_any_done(ok);
    check_val("t4_next_done", ok, 1);
    m_wr_req[0] = 0;
    repeat (3) @(negedge clk);
    check_val("t4_err_port_held", m_err_port, 3);

    // 5: reset during ISSUE, then a pending port-1 read wins first
    rd_lat = 20;
    push(0, A0, ctrl_rd_data(A0), 0);
    m_rd_req[0] = 1;
    for (c = 0; c < 50 && !m_oRd_Req; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    m_rd_req = 2'b10;
    rst = 1; sb.delete();
    @(negedge clk);
    check_val("t5_rd_req", m_oRd_Req, 0);
    check_val("t5_busy", m_busy, 0);
    check_val("t5_err_port", m_err_port, 0);
    check_val("t5_rd_addr", m_oRd_Addr, 0);
    check_val("t5_wr_data", m_oWr_Data, 0);
    @(negedge clk);
    rd_lat = 3;
    push(1, A1, ctrl_rd_data(A1), 0);
    rst = 0;
    wait_any_done(ok);
    check_val("t5_done_seen", ok, 1);
    m_rd_req = '0;
    repeat (3) @(negedge clk);

    // 6: en low while in DONE freezes the pulse
    push(0, A0, ctrl_rd_data(A0), 0);
    m_rd_req[0] = 1;
    wait_any_done(ok);
    check_val("t6_done_seen", ok, 1);
    chk_width = 0;
    en = 0;
    m_rd_req[0] = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t6_done_held", m_rd_done[0], 1);
    end
    check_val("t6_busy_held", m_busy, 1);
    en = 1;
    @(negedge clk);
    check_val("t6_done_clear", m_rd_done[0], 0);
    check_val("t6_gap_busy", m_busy, 1);
    @(negedge clk);
    check_val("t6_idle", m_busy, 0);
    chk_width = 1;
    repeat (3) @(negedge clk);
    check_val("final_sb_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
